// File: rtl/stepper_move_sequencer.sv
// stepper_move_sequencer
// Runs one coordinated two-axis move toward absolute joint targets. Bresenham
// interpolation makes both axes start and finish together. The block also
// tracks the joint positions in steps.
//
// Ports:
//   clk, reset                 clock and synchronous active-high reset
//   move_valid / move_ready    target handshake, accepted in IDLE only
//   th1_target, th2_target     absolute joint targets (unsigned steps)
//   abort                      end the current move early (still pulses done)
//   pos_clear                  zero both positions, honoured in IDLE only
//   th1_step, th2_step         step pulses, HIGH cycles wide, one per DIV cycles
//   th1_dir, th2_dir           1 = increasing position
//   th1_pos, th2_pos           current position in steps
//   busy, done                 move in progress / one-cycle end-of-move pulse
module stepper_move_sequencer #(
    parameter int unsigned STEP_W    = 14,
    parameter int unsigned DIV       = 1000,
    parameter int unsigned HIGH      = 100,
    parameter int unsigned DIR_SETUP = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              move_valid,
    output logic              move_ready,
    input  logic [STEP_W-1:0] th1_target,
    input  logic [STEP_W-1:0] th2_target,
    input  logic              abort,
    input  logic              pos_clear,
    output logic              th1_step,
    output logic              th2_step,
    output logic              th1_dir,
    output logic              th2_dir,
    output logic [STEP_W-1:0] th1_pos,
    output logic [STEP_W-1:0] th2_pos,
    output logic              busy,
    output logic              done
);

    localparam int unsigned CNT_MAX = (DIV > DIR_SETUP) ? DIV : DIR_SETUP;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(DIR_SETUP - 1);
    localparam logic [CNT_W-1:0] HI_LAST    = CNT_W'(HIGH - 1);
    localparam logic [CNT_W-1:0] LO_LAST    = CNT_W'(DIV - HIGH - 1);

    typedef enum logic [2:0] {StIdle, StSetup, StStepHi, StStepLo, StDone} state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [STEP_W:0]     tick_q, tick_d;
    logic [STEP_W:0]     major_q, major_d;
    logic [STEP_W:0]     minor_q, minor_d;
    logic [STEP_W+1:0]   err_q, err_d;
    logic                th1_major_q, th1_major_d;
    logic                dir1_q, dir1_d, dir2_q, dir2_d;
    logic                step1_q, step1_d, step2_q, step2_d;
    logic [STEP_W-1:0]   pos1_q, pos1_d, pos2_q, pos2_d;
    logic                busy_q, busy_d, done_q, done_d, ready_q, ready_d;
    logic                start_tick, finish;

    // Accept-time deltas; a same-cycle pos_clear makes the move start from zero.
    logic [STEP_W-1:0]   base1, base2;
    logic signed [STEP_W:0] d1, d2;
    logic [STEP_W:0]     a1, a2;

    assign base1 = pos_clear ? '0 : pos1_q;
    assign base2 = pos_clear ? '0 : pos2_q;
    assign d1    = $signed({1'b0, th1_target}) - $signed({1'b0, base1});
    assign d2    = $signed({1'b0, th2_target}) - $signed({1'b0, base2});
    assign a1    = d1[STEP_W] ? $unsigned(-d1) : $unsigned(d1);
    assign a2    = d2[STEP_W] ? $unsigned(-d2) : $unsigned(d2);

    logic [STEP_W+1:0]   err_sum;
    logic                minor_hit;

    assign err_sum   = err_q + {1'b0, minor_q};
    assign minor_hit = (err_sum >= {1'b0, major_q});

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tick_d      = tick_q;
        major_d     = major_q;
        minor_d     = minor_q;
        err_d       = err_q;
        th1_major_d = th1_major_q;
        dir1_d      = dir1_q;
        dir2_d      = dir2_q;
        step1_d     = 1'b0;
        step2_d     = 1'b0;
        pos1_d      = pos1_q;
        pos2_d      = pos2_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        ready_d     = ready_q;
        start_tick  = 1'b0;
        finish      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (pos_clear) begin
                    pos1_d = '0;
                    pos2_d = '0;
                end
                if (move_valid && ready_q) begin
                    dir1_d      = !d1[STEP_W] && (d1 != '0);
                    dir2_d      = !d2[STEP_W] && (d2 != '0);
                    // Ties make th1 the major axis.
                    th1_major_d = (a1 >= a2);
                    major_d     = (a1 >= a2) ? a1 : a2;
                    minor_d     = (a1 >= a2) ? a2 : a1;
                    err_d       = {1'b0, major_d >> 1};
                    tick_d      = '0;
                    cnt_d       = '0;
                    state_d     = StSetup;
                    busy_d      = 1'b1;
                    ready_d     = 1'b0;
                end
            end
            StSetup: begin
                if (abort) begin
                    finish = 1'b1;
                end else if (cnt_q == SETUP_LAST) begin
                    if (major_q == '0) finish = 1'b1;
                    else               start_tick = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StStepHi: begin
                if (abort) begin
                    finish = 1'b1;
                end else if (cnt_q == HI_LAST) begin
                    state_d = StStepLo;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    step1_d = step1_q;
                    step2_d = step2_q;
                end
            end
            StStepLo: begin
                if (abort) begin
                    finish = 1'b1;
                end else if (cnt_q == LO_LAST) begin
                    if (tick_q == major_q) finish = 1'b1;
                    else                   start_tick = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
                busy_d  = 1'b0;
                ready_d = 1'b1;
            end
            default: state_d = StIdle;
        endcase

        // Tick: major axis always steps, minor axis when the error overflows.
        // Position moves on the same edge the step output rises.
        if (start_tick) begin
            state_d = StStepHi;
            cnt_d   = '0;
            tick_d  = tick_q + (STEP_W + 1)'(1);
            err_d   = minor_hit ? (err_sum - {1'b0, major_q}) : err_sum;
            step1_d = th1_major_q | minor_hit;
            step2_d = !th1_major_q | minor_hit;
            if (step1_d) pos1_d = dir1_q ? (pos1_q + STEP_W'(1)) : (pos1_q - STEP_W'(1));
            if (step2_d) pos2_d = dir2_q ? (pos2_q + STEP_W'(1)) : (pos2_q - STEP_W'(1));
        end

        if (finish) begin
            state_d = StDone;
            done_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            tick_q      <= '0;
            major_q     <= '0;
            minor_q     <= '0;
            err_q       <= '0;
            th1_major_q <= 1'b0;
            dir1_q      <= 1'b0;
            dir2_q      <= 1'b0;
            step1_q     <= 1'b0;
            step2_q     <= 1'b0;
            pos1_q      <= '0;
            pos2_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tick_q      <= tick_d;
            major_q     <= major_d;
            minor_q     <= minor_d;
            err_q       <= err_d;
            th1_major_q <= th1_major_d;
            dir1_q      <= dir1_d;
            dir2_q      <= dir2_d;
            step1_q     <= step1_d;
            step2_q     <= step2_d;
            pos1_q      <= pos1_d;
            pos2_q      <= pos2_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ready_q     <= ready_d;
        end
    end

    assign move_ready = ready_q;
    assign th1_step   = step1_q;
    assign th2_step   = step2_q;
    assign th1_dir    = dir1_q;
    assign th2_dir    = dir2_q;
    assign th1_pos    = pos1_q;
    assign th2_pos    = pos2_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_stepper_move_sequencer.sv
// Bench for stepper_move_sequencer: directed and random moves are checked
// cycle by cycle against a schedule model. The model derives pulse times from
// the tick formula and the minor-axis step count from a closed-form Bresenham
// count.
module tb_stepper_move_sequencer;

    localparam int unsigned STEP_W = 14;
    localparam int unsigned DIV    = 10;
    localparam int unsigned HIGH   = 3;
    localparam int unsigned DS     = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              move_valid;
    logic              move_ready;
    logic [STEP_W-1:0] th1_target;
    logic [STEP_W-1:0] th2_target;
    logic              abort;
    logic              pos_clear;
    logic              th1_step, th2_step, th1_dir, th2_dir;
    logic [STEP_W-1:0] th1_pos, th2_pos;
    logic              busy, done;

    int checks   = 0;
    int failures = 0;
    int m_p1     = 0;
    int m_p2     = 0;

    stepper_move_sequencer #(
        .STEP_W   (STEP_W),
        .DIV      (DIV),
        .HIGH     (HIGH),
        .DIR_SETUP(DS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .move_valid(move_valid),
        .move_ready(move_ready),
        .th1_target(th1_target),
        .th2_target(th2_target),
        .abort     (abort),
        .pos_clear (pos_clear),
        .th1_step  (th1_step),
        .th2_step  (th2_step),
        .th1_dir   (th1_dir),
        .th2_dir   (th2_dir),
        .th1_pos   (th1_pos),
        .th2_pos   (th2_pos),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Minor-axis steps taken after i ticks: floor((major/2 + i*minor) / major).
    function automatic int minor_steps(input int i, input int maj, input int mnr);
        return (maj == 0) ? 0 : ((maj / 2) + i * mnr) / maj;
    endfunction

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_ready"}, 32'(move_ready), 1);
        check_eq({tag, "_busy"},  32'(busy), 0);
        check_eq({tag, "_done"},  32'(done), 0);
        check_eq({tag, "_step1"}, 32'(th1_step), 0);
        check_eq({tag, "_step2"}, 32'(th2_step), 0);
        check_eq({tag, "_dir1"},  32'(th1_dir), 0);
        check_eq({tag, "_dir2"},  32'(th2_dir), 0);
        check_eq({tag, "_pos1"},  32'(th1_pos), 0);
        check_eq({tag, "_pos2"},  32'(th2_pos), 0);
    endtask

    // One move from the model position to (t1,t2). abort_off > 0 raises abort
    // during that cycle after the handshake; junk drives move_valid during the
    // move; clr_busy pulses pos_clear during the move.
    task automatic run_move(input int t1, input int t2, input int abort_off,
                            input bit junk, input bit clr_busy);
        int d1, d2, a1, a2, maj, mnr, sg1, sg2, s, end_off, guard;
        int lim, n, ph, i, e_p1, e_p2;
        bit th1maj, e_dir1, e_dir2, maj_on, mnr_on, e_st1, e_st2;

        guard = 0;
        while (move_ready !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check_eq("ready_pre", 32'(move_ready), 1);

        d1     = t1 - m_p1;
        d2     = t2 - m_p2;
        a1     = (d1 < 0) ? -d1 : d1;
        a2     = (d2 < 0) ? -d2 : d2;
        sg1    = (d1 < 0) ? -1 : 1;
        sg2    = (d2 < 0) ? -1 : 1;
        e_dir1 = (d1 > 0);
        e_dir2 = (d2 > 0);
        th1maj = (a1 >= a2);
        maj    = th1maj ? a1 : a2;
        mnr    = th1maj ? a2 : a1;
        s      = 1 + DS;
        end_off = (abort_off > 0) ? abort_off + 1 : s + maj * DIV;
        e_p1   = m_p1;
        e_p2   = m_p2;

        move_valid = 1'b1;
        th1_target = t1[STEP_W-1:0];
        th2_target = t2[STEP_W-1:0];

        for (int off = 1; off <= end_off + 1; off++) begin
            @(negedge clk);
            lim = (off < end_off) ? off : end_off - 1;
            if (lim < s) n = 0;
            else begin
                n = (lim - s) / DIV + 1;
                if (n > maj) n = maj;
            end
            e_st1 = 1'b0;
            e_st2 = 1'b0;
            if (off >= s && off < end_off) begin
                ph     = (off - s) % DIV;
                i      = (off - s) / DIV + 1;
                maj_on = (ph < HIGH);
                mnr_on = (ph < HIGH) && (minor_steps(i, maj, mnr) > minor_steps(i - 1, maj, mnr));
                e_st1  = th1maj ? maj_on : mnr_on;
                e_st2  = th1maj ? mnr_on : maj_on;
            end
            e_p1 = m_p1 + sg1 * (th1maj ? n : minor_steps(n, maj, mnr));
            e_p2 = m_p2 + sg2 * (th1maj ? minor_steps(n, maj, mnr) : n);

            check_eq($sformatf("step1@%0d", off), 32'(th1_step), 32'(e_st1));
            check_eq($sformatf("step2@%0d", off), 32'(th2_step), 32'(e_st2));
            check_eq($sformatf("pos1@%0d", off), 32'(th1_pos), 32'(e_p1));
            check_eq($sformatf("pos2@%0d", off), 32'(th2_pos), 32'(e_p2));
            check_eq($sformatf("dir1@%0d", off), 32'(th1_dir), 32'(e_dir1));
            check_eq($sformatf("dir2@%0d", off), 32'(th2_dir), 32'(e_dir2));
            check_eq($sformatf("done@%0d", off), 32'(done), 32'(off == end_off));
            check_eq($sformatf("busy@%0d", off), 32'(busy), 32'(off <= end_off));
            check_eq($sformatf("ready@%0d", off), 32'(move_ready), 32'(off > end_off));

            move_valid = junk && (off < end_off);
            if (junk) begin
                th1_target = STEP_W'($urandom_range(0, 60));
                th2_target = STEP_W'($urandom_range(0, 60));
            end
            abort     = (off == abort_off);
            pos_clear = clr_busy && (off < end_off) && ($urandom_range(0, 3) == 0);
        end
        m_p1 = e_p1;
        m_p2 = e_p2;
    endtask

    initial begin
        int t1, t2, maj, ab;

        reset      = 1'b1;
        move_valid = 1'b0;
        abort      = 1'b0;
        pos_clear  = 1'b0;
        th1_target = '0;
        th2_target = '0;
        repeat (2) @(negedge clk);
        check_reset_values("rst");
        reset = 1'b0;
        @(negedge clk);

        run_move(8, 4, -1, 1'b0, 1'b0);
        run_move(2, 10, -1, 1'b0, 1'b0);
        run_move(2, 10, -1, 1'b0, 1'b0);

        pos_clear = 1'b1;
        @(negedge clk);
        pos_clear = 1'b0;
        check_eq("clr_pos1", 32'(th1_pos), 0);
        check_eq("clr_pos2", 32'(th2_pos), 0);
        m_p1 = 0;
        m_p2 = 0;

        run_move(8, 0, 26, 1'b0, 1'b0);
        run_move(15, 3, -1, 1'b1, 1'b0);
        run_move(1, 12, -1, 1'b0, 1'b1);

        for (int k = 0; k < 24; k++) begin
            t1 = $urandom_range(0, 30);
            t2 = $urandom_range(0, 30);
            if ($urandom_range(0, 3) == 0 && m_p2 - (t1 - m_p1) >= 0 && m_p2 - (t1 - m_p1) <= 30)
                t2 = m_p2 - (t1 - m_p1);
            maj = (t1 > m_p1) ? t1 - m_p1 : m_p1 - t1;
            if (((t2 > m_p2) ? t2 - m_p2 : m_p2 - t2) > maj)
                maj = (t2 > m_p2) ? t2 - m_p2 : m_p2 - t2;
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, DS + maj * DIV)) : -1;
            run_move(t1, t2, ab, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Reset mid-move: back to reset values with no done pulse.
        move_valid = 1'b1;
        th1_target = STEP_W'(20);
        th2_target = STEP_W'(15);
        @(negedge clk);
        move_valid = 1'b0;
        repeat (22) @(negedge clk);
        check_eq("mid_busy", 32'(busy), 1);
        reset = 1'b1;
        @(negedge clk);
        check_reset_values("rst_mid1");
        @(negedge clk);
        check_reset_values("rst_mid2");
        reset = 1'b0;
        @(negedge clk);
        check_eq("post_rst_done", 32'(done), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
